// File: rtl/local_branch_predictor_pkg.sv
// Shared geometry, types and counter helper for the two-level local branch predictor.
// Sized like a 32-bit CVA6 frontend with compressed instructions and two fetch slots.
package local_branch_predictor_pkg;

    localparam int VLEN            = 32;
    localparam int INSTR_PER_FETCH = 2;
    localparam int RVC             = 1;
    localparam int LBP_ENTRIES     = 64;
    localparam int LHR_ENTRIES     = 64;

    localparam int PT_ROWS        = LBP_ENTRIES / INSTR_PER_FETCH;
    localparam int LHT_ROWS       = LHR_ENTRIES / INSTR_PER_FETCH;
    localparam int LOCAL_IDX_BITS = $clog2(PT_ROWS);
    localparam int OFS            = (RVC != 0) ? 1 : 2;
    localparam int BANK_BITS      = $clog2(INSTR_PER_FETCH);
    localparam int LHT_ROW_BITS   = $clog2(LHT_ROWS);
    localparam int LHT_ROW_LSB    = OFS + BANK_BITS;

    typedef struct packed {
        logic [LOCAL_IDX_BITS-1:0] index;
    } bp_metadata_t;

    typedef struct packed {
        logic              valid;
        logic [VLEN-1:0]   pc;
        logic              taken;
        bp_metadata_t      metadata;
    } bht_update_t;

    typedef struct packed {
        logic         valid;
        logic         taken;
        bp_metadata_t metadata;
    } bht_prediction_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } pt_entry_t;

    // A never-trained entry starts weakly biased toward the first outcome seen.
    function automatic pt_entry_t pt_next(input pt_entry_t old, input logic taken);
        pt_entry_t nxt;
        nxt.valid = 1'b1;
        if (!old.valid) begin
            nxt.ctr = taken ? 2'b10 : 2'b01;
        end else if (taken) begin
            nxt.ctr = (old.ctr == 2'b11) ? 2'b11 : old.ctr + 2'd1;
        end else begin
            nxt.ctr = (old.ctr == 2'b00) ? 2'b00 : old.ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/local_branch_predictor_lbp_ram.sv
// Small table with two combinational read ports and one synchronous write port.
// Contents are never reset; a testbench may preload mem hierarchically.
module lbp_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 3,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata_a_o = mem[raddr_a_i];
    assign rdata_b_o = mem[raddr_b_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/local_branch_predictor.sv
// Two-level local branch predictor: per-bank history table feeding a per-bank
// pattern table of 2-bit counters, one bank per fetch slot.
module local_branch_predictor
    import local_branch_predictor_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            debug_mode_i,
    input  logic            flush_bp_i,
    input  logic [VLEN-1:0] vpc_i,
    input  bht_update_t     bht_update_i,
    output bht_prediction_t bht_prediction_o [INSTR_PER_FETCH]
);

    logic                      upd_en;
    logic [BANK_BITS-1:0]      upd_bank;
    logic [LHT_ROW_BITS-1:0]   upd_row;
    logic [LHT_ROW_BITS-1:0]   pred_row;
    logic                      unused_inputs;

    // Writes are gated by reset level rather than clocked reset, since the tables hold no reset state.
    assign upd_en   = rst_ni & bht_update_i.valid & ~debug_mode_i;
    assign upd_bank = bht_update_i.pc[OFS +: BANK_BITS];
    assign upd_row  = bht_update_i.pc[LHT_ROW_LSB +: LHT_ROW_BITS];
    assign pred_row = vpc_i[LHT_ROW_LSB +: LHT_ROW_BITS];

    assign unused_inputs = ^{flush_bp_i, vpc_i, bht_update_i.pc};

    for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : gen_bank
        logic                      we;
        logic [LOCAL_IDX_BITS-1:0] pred_hist;
        logic [LOCAL_IDX_BITS-1:0] upd_hist_old;
        logic [LOCAL_IDX_BITS-1:0] upd_hist_new;
        pt_entry_t                 pred_pt;
        pt_entry_t                 upd_pt_old;
        pt_entry_t                 upd_pt_new;
        logic                      unused_hist_msb;

        assign we              = upd_en && (upd_bank == BANK_BITS'(i));
        assign upd_hist_new    = {upd_hist_old[LOCAL_IDX_BITS-2:0], bht_update_i.taken};
        assign upd_pt_new      = pt_next(upd_pt_old, bht_update_i.taken);
        assign unused_hist_msb = upd_hist_old[LOCAL_IDX_BITS-1];

        lbp_ram #(
            .DEPTH (LHT_ROWS),
            .WIDTH (LOCAL_IDX_BITS)
        ) i_lht_ram (
            .clk_i     (clk_i),
            .we_i      (we),
            .waddr_i   (upd_row),
            .wdata_i   (upd_hist_new),
            .raddr_a_i (pred_row),
            .rdata_a_o (pred_hist),
            .raddr_b_i (upd_row),
            .rdata_b_o (upd_hist_old)
        );

        // The update addresses the PT with the returned history, not a fresh LHT read.
        lbp_ram #(
            .DEPTH (PT_ROWS),
            .WIDTH ($bits(pt_entry_t))
        ) i_pt_ram (
            .clk_i     (clk_i),
            .we_i      (we),
            .waddr_i   (bht_update_i.metadata.index),
            .wdata_i   (upd_pt_new),
            .raddr_a_i (pred_hist),
            .rdata_a_o (pred_pt),
            .raddr_b_i (bht_update_i.metadata.index),
            .rdata_b_o (upd_pt_old)
        );

        assign bht_prediction_o[i] = '{valid:    pred_pt.valid,
                                       taken:    pred_pt.ctr[1],
                                       metadata: '{index: pred_hist}};
    end

endmodule

// File: tb/tb_local_branch_predictor.sv
// Directed and shadow-model checks of the local branch predictor.
module tb_local_branch_predictor;
    import local_branch_predictor_pkg::*;

    logic            clk_i;
    logic            rst_ni;
    logic            debug_mode_i;
    logic            flush_bp_i;
    logic [31:0]     vpc_i;
    bht_update_t     upd;
    bht_prediction_t pred [2];

    int total_checks;
    int bad_checks;

    logic [4:0] lht_m [2][32];
    logic [2:0] pt_m  [2][32];

    local_branch_predictor dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .debug_mode_i     (debug_mode_i),
        .flush_bp_i       (flush_bp_i),
        .vpc_i            (vpc_i),
        .bht_update_i     (upd),
        .bht_prediction_o (pred)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_pt(input int b, input int idx, input logic [2:0] v);
        if (b == 0) dut.gen_bank[0].i_pt_ram.mem[idx] = v;
        else        dut.gen_bank[1].i_pt_ram.mem[idx] = v;
        pt_m[b][idx] = v;
    endtask

    task automatic set_lht(input int b, input int idx, input logic [4:0] v);
        if (b == 0) dut.gen_bank[0].i_lht_ram.mem[idx] = v;
        else        dut.gen_bank[1].i_lht_ram.mem[idx] = v;
        lht_m[b][idx] = v;
    endtask

    function automatic logic [2:0] get_pt(input int b, input int idx);
        if (b == 0) return dut.gen_bank[0].i_pt_ram.mem[idx];
        return dut.gen_bank[1].i_pt_ram.mem[idx];
    endfunction

    function automatic logic [4:0] get_lht(input int b, input int idx);
        if (b == 0) return dut.gen_bank[0].i_lht_ram.mem[idx];
        return dut.gen_bank[1].i_lht_ram.mem[idx];
    endfunction

    task automatic init_tables(input bit rnd);
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 32; j++) begin
                set_lht(b, j, rnd ? 5'($urandom) : 5'd0);
                set_pt(b, j, rnd ? 3'($urandom) : 3'd0);
            end
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic tk, input logic [4:0] idx);
        upd.valid          = v;
        upd.pc             = pc;
        upd.taken          = tk;
        upd.metadata.index = idx;
    endtask

    // Independent model: bank is pc[1], history row is pc[6:2].
    function automatic logic [6:0] model_pred(input int s, input logic [31:0] pc);
        logic [4:0] h;
        logic [2:0] e;
        h = lht_m[s][pc[6:2]];
        e = pt_m[s][h];
        return {e[2], e[1], h};
    endfunction

    task automatic model_update();
        int b;
        int r;
        logic [2:0] old;
        logic [2:0] nxt;
        b   = int'(upd.pc[1]);
        r   = int'(upd.pc[6:2]);
        old = pt_m[b][upd.metadata.index];
        if (!old[2])        nxt = upd.taken ? 3'b110 : 3'b101;
        else if (upd.taken) nxt = (old[1:0] == 2'd3) ? 3'b111 : {1'b1, old[1:0] + 2'd1};
        else                nxt = (old[1:0] == 2'd0) ? 3'b100 : {1'b1, old[1:0] - 2'd1};
        pt_m[b][upd.metadata.index] = nxt;
        lht_m[b][r] = {lht_m[b][r][3:0], upd.taken};
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        rst_ni       = 1'b0;
        debug_mode_i = 1'b0;
        flush_bp_i   = 1'b0;
        vpc_i        = 32'h8000_0000;
        apply_stimulus(1'b0, 32'h0, 1'b0, 5'd0);
        init_tables(1'b0);
        #2;
        check_output("rst_slot0", 32'(pred[0]), 32'h00);
        check_output("rst_slot1", 32'(pred[1]), 32'h00);

        // Outputs follow the tables while in reset; updates are ignored.
        set_pt(0, 5, 3'b111);
        set_lht(0, 0, 5'd5);
        #1;
        check_output("rst_follow", 32'(pred[0]), 32'h65);
        apply_stimulus(1'b1, 32'h8000_0000, 1'b1, 5'd5);
        step();
        check_output("rst_upd_pt", 32'(get_pt(0, 5)), 32'h7);
        check_output("rst_upd_lht", 32'(get_lht(0, 0)), 32'd5);
        rst_ni = 1'b1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 5'd0);
        step();

        check_output("pred_hit", 32'(pred[0]), 32'h65);
        apply_stimulus(1'b1, 32'h8000_0000, 1'b0, 5'd5);
        #1;
        check_output("rdw_old", 32'(pred[0]), 32'h65);
        step();
        apply_stimulus(1'b0, 32'h0, 1'b0, 5'd0);
        check_output("upd_pt5", 32'(get_pt(0, 5)), 32'h6);
        check_output("upd_lht", 32'(get_lht(0, 0)), 32'd10);
        check_output("pred_idx10", 32'(pred[0]), 32'h0A);

        set_pt(0, 7, 3'b101);
        apply_stimulus(1'b1, 32'h8000_0040, 1'b0, 5'd7);
        for (int k = 0; k < 4; k++) begin
            step();
            check_output("sat_lo", 32'(get_pt(0, 7)), 32'h4);
        end
        set_pt(0, 8, 3'b110);
        apply_stimulus(1'b1, 32'h8000_0040, 1'b1, 5'd8);
        for (int k = 0; k < 4; k++) begin
            step();
            check_output("sat_hi", 32'(get_pt(0, 8)), 32'h7);
        end
        check_output("lht_shift", 32'(get_lht(0, 16)), 32'd15);

        apply_stimulus(1'b1, 32'h8000_0040, 1'b1, 5'd12);
        step();
        check_output("inv_taken", 32'(get_pt(0, 12)), 32'h6);
        apply_stimulus(1'b1, 32'h8000_0040, 1'b0, 5'd13);
        step();
        check_output("inv_ntaken", 32'(get_pt(0, 13)), 32'h5);

        debug_mode_i = 1'b1;
        apply_stimulus(1'b1, 32'h8000_0000, 1'b1, 5'd10);
        step();
        check_output("dbg_pt", 32'(get_pt(0, 10)), 32'h0);
        check_output("dbg_lht", 32'(get_lht(0, 0)), 32'd10);
        check_output("dbg_pred", 32'(pred[0]), 32'h0A);
        debug_mode_i = 1'b0;
        rst_ni = 1'b0;
        step();
        check_output("rst2_pt", 32'(get_pt(0, 10)), 32'h0);
        check_output("rst2_lht", 32'(get_lht(0, 0)), 32'd10);
        check_output("rst2_pred", 32'(pred[0]), 32'h0A);
        rst_ni = 1'b1;

        apply_stimulus(1'b1, 32'h8000_0002, 1'b1, 5'd3);
        step();
        apply_stimulus(1'b0, 32'h0, 1'b0, 5'd0);
        check_output("b1_pt", 32'(get_pt(1, 3)), 32'h6);
        check_output("b1_lht", 32'(get_lht(1, 0)), 32'd1);
        check_output("b0_pt_keep", 32'(get_pt(0, 3)), 32'h0);
        check_output("b0_lht_keep", 32'(get_lht(0, 0)), 32'd10);
        check_output("b1_slot1", 32'(pred[1]), 32'h01);
        check_output("b1_slot0", 32'(pred[0]), 32'h0A);

        // Random stream against the shadow model, prediction sampled before each edge.
        init_tables(1'b1);
        for (int n = 0; n < 10000; n++) begin
            vpc_i        = $urandom;
            debug_mode_i = ($urandom_range(0, 7) == 0);
            apply_stimulus(($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 5'($urandom));
            #2;
            check_output("rnd_slot0", 32'(pred[0]), 32'(model_pred(0, vpc_i)));
            check_output("rnd_slot1", 32'(pred[1]), 32'(model_pred(1, vpc_i)));
            if (upd.valid && !debug_mode_i) model_update();
            step();
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/local_branch_predictor.md
Name: local_branch_predictor

Overview:
- Two-level local branch predictor for the CVA6 frontend; one prediction per fetch slot, INSTR_PER_FETCH slots.
- Level 1, the local history table (LHT), is indexed by fetch PC and holds per-branch taken/not-taken history.
- Level 2, the pattern table (PT), is indexed by that history and holds 2-bit saturating counters.
- The history used for prediction is returned as metadata so the resolved-branch update writes exactly the PT entry that predicted.

Parameters:
- CVA6Cfg, cva6 default config: supplies VLEN, INSTR_PER_FETCH (IPF), RVC, LocalPredictorIndexBits.
- bht_update_t, per CVA6Cfg: {valid, pc[VLEN], taken, metadata}.
- bht_prediction_t, per CVA6Cfg: {valid, taken, metadata}.
- bp_metadata_t, per CVA6Cfg: {index[LocalPredictorIndexBits]}.
- LBP_ENTRIES, CVA6Cfg.LocalPredictorSize: total PT entries across all banks.
- LHR_ENTRIES, CVA6Cfg.LocalHistoryTableSize: total LHT entries across all banks.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- debug_mode_i  in  1  when 1, updates are suppressed
- flush_bp_i  in  1  predictor flush; accepted, no effect (tables are SRAM-like)
- vpc_i  in  VLEN  fetch virtual PC
- bht_update_i  in  bht_update_t  resolved-branch update
- bht_prediction_o  out  bht_prediction_t[IPF]  per-slot predictions

Behaviour:
- Geometry and index fields:
  - PT_ROWS = LBP_ENTRIES/IPF; LHT_ROWS = LHR_ENTRIES/IPF; H = LocalPredictorIndexBits = clog2(PT_ROWS).
  - OFS = RVC ? 1 : 2. Bank field = pc[OFS +: clog2(IPF)]. LHT row = pc[OFS+clog2(IPF) +: clog2(LHT_ROWS)].
- Storage: IPF banks, bank i used for slot i.
  - Each bank has one LHT RAM (LHT_ROWS x H bits, history) and one PT RAM (PT_ROWS x 3 bits: valid, ctr[1:0]).
  - RAMs are array "mem"; combinational read, synchronous write; storage is never reset or flushed (preloadable by hierarchical write).
- Prediction is purely combinational, zero-cycle latency. For each slot i:
  - h = LHT_i.mem[LHT row of vpc_i].
  - e = PT_i.mem[h].
  - bht_prediction_o[i] = {valid = e.valid, taken = e.ctr[1], metadata.index = h}.
- Update on posedge clk_i, only when rst_ni=1, bht_update_i.valid=1 and debug_mode_i=0. With b = bank of update pc, r = LHT row of update pc, p = metadata.index:
  - PT_b.mem[p]: valid←1. If old valid=0: ctr←taken ? 2'b10 : 2'b01. Else ctr saturating +1 if taken (max 3), -1 if not taken (min 0).
  - LHT_b.mem[r] ← {old[H-2:0], taken}, shifting left with the newest outcome in the LSB.
  - The PT and LHT writes happen in the same edge. Other banks are untouched.
- Read-during-write: a prediction in the update cycle returns pre-update contents; the new value is visible from the next cycle.
- Reset: no flops besides tables; outputs follow the tables during reset. Updates are ignored while rst_ni=0.
- Aliasing is permitted: different PCs that share a bank/row share history, and histories that collide share a counter.

Decomposition:
- Shared package: bp_metadata_t, bht_update_t, bht_prediction_t, the PT entry struct {valid, ctr[1:0]}, and the OFS/row-width helper constants.
- One natural sub-module: lbp_ram (DEPTH, WIDTH; mem array, async read, sync write enable). Instantiate it as i_lht_ram and i_pt_ram inside a generate loop gen_bank[IPF].

Test Plan (IPF=2, RVC=1):
- Preload bank0 PT mem[5]={1,2'b11}, LHT mem[row(0x80000000)]=5; vpc_i=0x80000000 -> slot0 {valid=1, taken=1, index=5} in the same cycle.
- Update {pc=0x80000000, taken=0, index=5}, debug=0 -> next cycle PT mem[5].ctr=2'b10 (prediction still taken); LHT row=(5<<1)|0 masked to H bits; slot0 index now 10.
- Four not-taken updates to an entry with ctr=2'b01 -> ctr reaches 0 and stays 0. Four taken updates to ctr=2'b10 -> ctr saturates at 3.
- Update to invalid PT entry with taken=1 -> entry becomes {1,2'b10}. With taken=0 -> {1,2'b01}.
- Update with debug_mode_i=1, or with rst_ni=0 -> no PT or LHT change; predictions identical before and after.
- pc=0x80000002 (bank1) update -> only bank1 tables change. Random 10000-cycle stream compared each cycle against a shadow model -> zero mismatches.
